hilo_muldiv: RTL and testbench

Parametrised HI/LO multiply/divide unit for the MIPS EX stage, successor to the combinational ALU auxiliary decoding of MULTU/MFHI/MFLO. It decodes the full HI/LO funct group (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) and runs multiply and divide on an iterative WIDTH-cycle engine that stalls the pipeline. It owns the architectural HI and LO registers and drives the MFHI/MFLO read value back to the writeback mux.

---
 rtl/hilo_pkg.sv | 35 +++
 rtl/hilo_iter_engine.sv | 115 +++++++++++
 rtl/hilo_muldiv.sv | 83 ++++++++
 tb/tb_hilo_muldiv.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - funct codes of the HI/LO instruction group
//   - FSM state encoding of the top-level sequencer
//   - decode helpers for group membership and multiply/divide ops
package hilo_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } hilo_state_e;

  function automatic logic is_hilo_op(input logic [5:0] funct);
    case (funct)
      FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix.
  function automatic logic is_muldiv_op(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/hilo_iter_engine.sv
// hilo_iter_engine: iterative WIDTH-cycle multiply/divide datapath.
//   clk, rst       clock, asynchronous active-high reset (control only)
//   start          one-cycle pulse: latch operands and op mode
//   is_div         1 = restoring divide, 0 = shift-add multiply
//   is_signed      operands are two's complement (MULT/DIV)
//   a, b           rs (multiplicand/dividend) and rt (multiplier/divisor)
//   done           high in the cycle of the last iteration
//   res_hi, res_lo sign-corrected result, valid once done has been seen
module hilo_iter_engine
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x,
                                             input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x,
                                                input logic n);
    return n ? -x : x;
  endfunction

  logic             active;
  logic [CNT_W-1:0] cnt;

  // acc_hi: upper product half / partial remainder.
  // acc_lo: multiplier bits still to consume / dividend bits becoming quotient.
  logic [WIDTH-1:0] acc_hi, acc_lo, op_b, rs_orig;
  logic             div_mode, div_zero, neg_res, neg_rem;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_sh, div_dif;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;
  logic [2*WIDTH-1:0] prod_fix;

  assign done = active && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CNT_W'(WIDTH - 1);
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  always_comb begin
    mul_sum                = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    {mul_hi_nx, mul_lo_nx} = {mul_sum, acc_lo[WIDTH-1:1]};
    div_sh                 = {acc_hi, acc_lo[WIDTH-1]};
    div_ge                 = div_sh >= {1'b0, op_b};
    div_dif                = div_sh - {1'b0, op_b};
    div_hi_nx              = div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_nx              = {acc_lo[WIDTH-2:0], div_ge};
  end

  // Load on start, one radix-2 step per active cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_hi   <= '0;
      acc_lo   <= magnitude(a, is_signed);
      op_b     <= magnitude(b, is_signed);
      rs_orig  <= a;
      div_mode <= is_div;
      div_zero <= is_div && (b == '0);
      neg_res  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= is_signed && a[WIDTH-1];
    end else if (active) begin
      acc_hi <= div_mode ? div_hi_nx : mul_hi_nx;
      acc_lo <= div_mode ? div_lo_nx : mul_lo_nx;
    end
  end

  // Sign fixup on the finished magnitudes; divide-by-zero overrides.
  always_comb begin
    prod_fix = neg_2w({acc_hi, acc_lo}, neg_res);
    if (div_mode && div_zero) begin
      res_hi = rs_orig;
      res_lo = '1;
    end else if (div_mode) begin
      res_hi = neg_w(acc_hi, neg_rem);
      res_lo = neg_w(acc_lo, neg_res);
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: MIPS EX-stage HI/LO unit (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
//   clk, rst    clock, asynchronous active-high reset
//   op_valid    R-type instruction present in EX
//   funct       instruction funct field
//   rs_data     dividend / multiplicand / MTHI-MTLO source
//   rt_data     divisor / multiplier
//   busy        multiply/divide in progress
//   stall       HI/LO-group instruction blocked by busy engine
//   hilo_rdata  HI when funct is MFHI, otherwise LO
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_rdata
);

  hilo_state_e      state, next_state;
  logic             hilo_op, accept, start, eng_done;
  logic [WIDTH-1:0] hi_reg, lo_reg, eng_hi, eng_lo;

  assign hilo_op    = op_valid && is_hilo_op(funct);
  assign accept     = hilo_op && !busy;
  assign start      = accept && is_muldiv_op(funct);
  assign stall      = hilo_op && busy;
  assign hilo_rdata = (funct == FN_MFHI) ? hi_reg : lo_reg;

  hilo_iter_engine #(.WIDTH(WIDTH)) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (funct[1]),
    .is_signed (!funct[0]),
    .a         (rs_data),
    .b         (rt_data),
    .done      (eng_done),
    .res_hi    (eng_hi),
    .res_lo    (eng_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = RUN;
      end
      RUN:     if (eng_done) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // HI/LO change only on MTHI/MTLO acceptance or in FIN, never mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state == FIN) begin
      hi_reg <= eng_hi;
      lo_reg <= eng_lo;
    end else if (accept && funct == FN_MTHI) begin
      hi_reg <= rs_data;
    end else if (accept && funct == FN_MTLO) begin
      lo_reg <= rs_data;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
  import hilo_pkg::*;

  localparam logic [5:0] FN_ADD = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        v32, v8;
  logic [5:0]  f32, f8;
  logic [31:0] a32, b32, rd32;
  logic [7:0]  a8, b8, rd8;
  logic        busy32, stall32, busy8, stall8;

  int checks = 0;
  int errors = 0;

  logic [31:0] mhi [2];
  logic [31:0] mlo [2];

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .op_valid(v32), .funct(f32), .rs_data(a32),
    .rt_data(b32), .busy(busy32), .stall(stall32), .hilo_rdata(rd32));

  hilo_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .op_valid(v8), .funct(f8), .rs_data(a8),
    .rt_data(b8), .busy(busy8), .stall(stall8), .hilo_rdata(rd8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin v32 = v; f32 = f; a32 = a; b32 = b; end
    else         begin v8 = v; f8 = f; a8 = a[7:0]; b8 = b[7:0]; end
  endtask

  function automatic logic s_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic s_stall(input int w);
    return (w == 32) ? stall32 : stall8;
  endfunction
  function automatic logic [31:0] s_rd(input int w);
    return (w == 32) ? rd32 : {24'd0, rd8};
  endfunction

  // Architectural reference: plain integer arithmetic on w-bit values.
  task automatic ref_muldiv(input int w, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] hi,
                            output logic [31:0] lo);
    logic [63:0] mask, ua, ub, bits;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    bits = '0;
    hi   = '0;
    lo   = '0;
    case (f)
      FN_MULT, FN_MULTU: begin
        if (f == FN_MULT) bits = sa * sb;
        else              bits = ua * ub;
        hi = 32'((bits >> w) & mask);
        lo = 32'(bits & mask);
      end
      FN_DIV, FN_DIVU: begin
        if (ub == 64'd0) begin
          lo = 32'(mask);
          hi = 32'(ua);
        end else if (f == FN_DIV) begin
          q = sa / sb;
          r = sa % sb;
          bits = q; lo = 32'(bits & mask);
          bits = r; hi = 32'(bits & mask);
        end else begin
          lo = 32'((ua / ub) & mask);
          hi = 32'((ua % ub) & mask);
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_mt(input int w, input logic [5:0] f, input logic [31:0] a);
    int idx;
    logic [31:0] mask;
    idx  = (w == 32) ? 1 : 0;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    @(negedge clk);
    drive(w, 1'b1, f, a, 32'd0);
    #1;
    chk("mt_no_stall", {31'd0, s_stall(w)}, 32'd0);
    if (f == FN_MTHI) mhi[idx] = a & mask;
    else              mlo[idx] = a & mask;
    @(negedge clk);
    drive(w, 1'b1, (f == FN_MTHI) ? FN_MFHI : FN_MFLO, 32'd0, 32'd0);
    #1;
    chk("mt_readback", s_rd(w), (f == FN_MTHI) ? mhi[idx] : mlo[idx]);
    drive(w, 1'b0, FN_ADD, 32'd0, 32'd0);
  endtask

  task automatic do_muldiv(input int w, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input bit probe);
    int idx, n;
    logic [31:0] nh, nl;
    idx = (w == 32) ? 1 : 0;
    @(negedge clk);
    drive(w, 1'b1, f, a, b);
    #1;
    chk("accept_no_stall", {31'd0, s_stall(w)}, 32'd0);
    @(negedge clk);
    ref_muldiv(w, f, a, b, nh, nl);
    mhi[idx] = nh;
    mlo[idx] = nl;
    if (probe) begin
      drive(w, 1'b0, FN_ADD, 32'd0, 32'd0);
      #1;
      chk("busy_after_accept", {31'd0, s_busy(w)}, 32'd1);
      @(negedge clk);
      drive(w, 1'b1, FN_MFHI, 32'd0, 32'd0);
      #1;
      n = 0;
      while (s_stall(w) && n < 200) begin
        n++;
        @(negedge clk);
        #1;
      end
      chk("mfhi_stall_cycles", n, w);
      chk("mfhi_after_stall", s_rd(w), mhi[idx]);
    end else begin
      drive(w, 1'b1, FN_MTLO, 32'hDEAD_BEEF, 32'd0);
      #1;
      chk("group_op_stalls", {31'd0, s_stall(w)}, 32'd1);
      drive(w, 1'b1, FN_ADD, a, b);
      #1;
      chk("add_no_stall", {31'd0, s_stall(w)}, 32'd0);
      drive(w, 1'b0, FN_ADD, 32'd0, 32'd0);
      #1;
      n = 0;
      while (s_busy(w) && n < 200) begin
        n++;
        @(negedge clk);
        #1;
      end
      chk("busy_cycles", n, w + 1);
      drive(w, 1'b1, FN_MFHI, 32'd0, 32'd0);
      #1;
      chk("mfhi_no_stall", {31'd0, s_stall(w)}, 32'd0);
      chk("hi_result", s_rd(w), mhi[idx]);
    end
    drive(w, 1'b1, FN_MFLO, 32'd0, 32'd0);
    #1;
    chk("lo_result", s_rd(w), mlo[idx]);
    drive(w, 1'b0, FN_ADD, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ones, neg7, minv, ra, rb;
    logic [5:0]  rf;
    logic [5:0]  ops [4];
    int          w;
    ops[0] = FN_MULT; ops[1] = FN_MULTU; ops[2] = FN_DIV; ops[3] = FN_DIVU;

    rst = 1'b1;
    drive(32, 1'b0, FN_ADD, 32'd0, 32'd0);
    drive(8,  1'b0, FN_ADD, 32'd0, 32'd0);
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    #1;
    chk("rst_busy32",  {31'd0, busy32},  32'd0);
    chk("rst_stall32", {31'd0, stall32}, 32'd0);
    chk("rst_rdata32", rd32, 32'd0);
    chk("rst_busy8",   {31'd0, busy8},   32'd0);
    chk("rst_rdata8",  {24'd0, rd8},     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int pass = 0; pass < 2; pass++) begin
      w    = (pass == 0) ? 32 : 8;
      ones = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      neg7 = 32'hFFFF_FFF9 & ones;
      minv = 32'd1 << (w - 1);

      do_muldiv(w, FN_MULTU, ones, ones, 1'b0);
      do_muldiv(w, FN_MULT, neg7, 32'd3, 1'b0);
      do_muldiv(w, FN_DIV, neg7, 32'd2, 1'b0);
      do_muldiv(w, FN_DIVU, 32'd100, 32'd0, 1'b1);
      do_muldiv(w, FN_DIV, neg7, 32'd0, 1'b0);
      do_muldiv(w, FN_DIV, minv, ones, 1'b0);
      do_mt(w, FN_MTLO, 32'h0000_1234);
      do_mt(w, FN_MTHI, 32'hA5A5_5A5A);

      for (int k = 0; k < 10; k++) begin
        rf = ops[$urandom_range(0, 3)];
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 5) == 0) rb = 32'd0;
        if ($urandom_range(0, 5) == 0) rb = 32'd1;
        do_muldiv(w, rf, ra, rb, k[0]);
      end
      do_mt(w, FN_MTLO, $urandom);
    end

    // Reset in the middle of a run on the 32-bit unit.
    @(negedge clk);
    drive(32, 1'b1, FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    drive(32, 1'b0, FN_ADD, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("busy_before_rst", {31'd0, busy32}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy32}, 32'd0);
    chk("rst_mid_rdata", rd32, 32'd0);
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(32, 1'b1, FN_MFLO, 32'd0, 32'd0);
    #1;
    chk("mflo_after_rst", rd32, mlo[1]);
    @(negedge clk);
    #1;
    chk("busy_stays_low", {31'd0, busy32}, 32'd0);
    drive(32, 1'b1, FN_MFHI, 32'd0, 32'd0);
    #1;
    chk("mfhi_after_rst", rd32, mhi[1]);
    drive(32, 1'b0, FN_ADD, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
